cordic_phase_feeder: RTL and testbench

//   Upstream feeder for the 32-stage CORDIC sin/cos pipeline. Burst/continuous NCO:
//   32-bit phase accumulator, full turn = 2^32. Folds each phase into [-pi/2, pi/2].

---
 rtl/cordic_phase_feeder.sv | 128 ++++++++++++
 tb/tb_cordic_phase_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_feeder.sv
// Phase accumulator and quadrant folder feeding the 32-stage CORDIC sin/cos pipeline.
// Optional CORDIC_PHASE_FLAG_DELAY_EN adds flags delayed to line up with the CORDIC outputs.
module cordic_phase_feeder #(
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
    parameter int unsigned CORDIC_LAT = 32,
`endif
    parameter logic [31:0] HALF_PI = 32'h6487ED51
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ftw,
    input  logic [31:0] phase_ofs,
    input  logic [15:0] burst_len,
    output logic        busy,
    output logic [31:0] theta_o,
    output logic        theta_valid_o,
    output logic        cos_neg_o
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
    ,
    output logic        res_valid_o,
    output logic        res_cos_neg_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q;
    logic        [31:0] acc_q;
    logic        [31:0] ftw_q;
    logic        [15:0] cnt_q;
    logic        [31:0] ps_q;
    logic               v1_q;
    logic               neg1_q;

    logic               issue;
    logic               fold;
    logic        [31:0] ps_d;
    logic signed [63:0] prod;
    logic        [31:0] theta_d;
    logic               drain_done;

    assign issue = (state_q == StRun) && !stop;

    // Quadrants 1 and 2 mirror about pi/2: angle -> pi - angle.
    assign fold = acc_q[31] ^ acc_q[30];
    assign ps_d = fold ? (32'h8000_0000 - acc_q) : acc_q;

    assign prod    = $signed({{32{ps_q[31]}}, ps_q}) * $signed({32'd0, HALF_PI});
    assign theta_d = 32'(prod >>> 30);

    assign busy = (state_q != StIdle);

`ifdef CORDIC_PHASE_FLAG_DELAY_EN
    logic [CORDIC_LAT-1:0] sr_v_q, sr_n_q, sr_v_d, sr_n_d;

    always_comb begin
        sr_v_d = (sr_v_q << 1) | CORDIC_LAT'(theta_valid_o);
        sr_n_d = (sr_n_q << 1) | CORDIC_LAT'(cos_neg_o);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_v_q <= '0;
            sr_n_q <= '0;
        end else begin
            sr_v_q <= sr_v_d;
            sr_n_q <= sr_n_d;
        end
    end

    assign res_valid_o   = sr_v_q[CORDIC_LAT-1];
    assign res_cos_neg_o = sr_n_q[CORDIC_LAT-1];
    // Leave DRAIN on the edge that empties the last pipeline register.
    assign drain_done    = !v1_q && (sr_v_d == '0);
`else
    assign drain_done    = !v1_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            ftw_q         <= '0;
            cnt_q         <= '0;
            ps_q          <= '0;
            v1_q          <= 1'b0;
            neg1_q        <= 1'b0;
            theta_o       <= '0;
            theta_valid_o <= 1'b0;
            cos_neg_o     <= 1'b0;
        end else begin
            v1_q          <= issue;
            theta_o       <= theta_d;
            theta_valid_o <= v1_q;
            cos_neg_o     <= neg1_q;
            if (issue) begin
                ps_q   <= ps_d;
                neg1_q <= fold;
                acc_q  <= acc_q + ftw_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        acc_q   <= phase_ofs;
                        ftw_q   <= ftw;
                        cnt_q   <= burst_len;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q <= StDrain;
                    end else begin
                        if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed bench for cordic_phase_feeder: reset, quarter steps, wrap, fold boundaries, control
// collisions, and (with CORDIC_PHASE_FLAG_DELAY_EN) the delayed flag outputs.
module tb_cordic_phase_feeder;

    localparam logic [31:0] H   = 32'h6487ED51;
    localparam int          LAT = 32;
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
    localparam int DRAIN_EXTRA = LAT;
`else
    localparam int DRAIN_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, stop;
    logic [31:0] ftw, phase_ofs;
    logic [15:0] burst_len;
    logic        busy, theta_valid_o, cos_neg_o;
    logic [31:0] theta_o;
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
    logic        res_valid_o, res_cos_neg_o;
`endif

    always #5 clk = ~clk;

    cordic_phase_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .ftw          (ftw),
        .phase_ofs    (phase_ofs),
        .burst_len    (burst_len),
        .busy         (busy),
        .theta_o      (theta_o),
        .theta_valid_o(theta_valid_o),
        .cos_neg_o    (cos_neg_o)
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
        ,
        .res_valid_o  (res_valid_o),
        .res_cos_neg_o(res_cos_neg_o)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cap_en   = 1'b0;

    logic [31:0] q_theta[$];
    logic        q_neg[$];
    int          q_cyc[$];
    logic        r_neg[$];
    int          r_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cap_en && theta_valid_o) begin
            q_theta.push_back(theta_o);
            q_neg.push_back(cos_neg_o);
            q_cyc.push_back(cyc);
        end
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
        if (cap_en && res_valid_o) begin
            r_neg.push_back(res_cos_neg_o);
            r_cyc.push_back(cyc);
        end
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: fold by quadrant on the unsigned phase, then floor(a * H / 2^30).
    function automatic logic [32:0] model(input logic [31:0] ph);
        longint u, a, p;
        logic   neg;
        u = longint'({32'd0, ph});
        case (ph[31:30])
            2'd0:    begin a = u;                       neg = 1'b0; end
            2'd1:    begin a = 64'sh8000_0000 - u;      neg = 1'b1; end
            2'd2:    begin a = -(u - 64'sh8000_0000);   neg = 1'b1; end
            default: begin a = u - 64'sh1_0000_0000;    neg = 1'b0; end
        endcase
        p = a * longint'({32'd0, H});
        p = p >>> 30;
        return {neg, p[31:0]};
    endfunction

    task automatic clear_q();
        q_theta.delete(); q_neg.delete(); q_cyc.delete();
        r_neg.delete();   r_cyc.delete();
    endtask

    task automatic pulse_start(input logic [31:0] f, input logic [31:0] o, input logic [15:0] n);
        @(negedge clk);
        ftw = f; phase_ofs = o; burst_len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q2_theta[4];
        logic        q2_neg[4];
        logic [31:0] b_ofs[4];
        logic [31:0] b_theta[4];
        logic        b_neg[4];
        logic        any;
        int          s0, sedge;

        q2_theta = '{32'h0000_0000, 32'h6487_ED51, 32'h0000_0000, 32'h9B78_12AF};
        q2_neg   = '{1'b0, 1'b1, 1'b1, 1'b0};
        b_ofs    = '{32'h3FFF_FFFF, 32'h4000_0000, 32'hBFFF_FFFF, 32'hC000_0000};
        b_theta  = '{32'h6487_ED4F, 32'h6487_ED51, 32'h9B78_12B0, 32'h9B78_12AF};
        b_neg    = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        ftw = '0; phase_ofs = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        check("rst_theta", 64'(theta_o), 64'd0);
        check("rst_valid", 64'(theta_valid_o), 64'd0);
        check("rst_cos_neg", 64'(cos_neg_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Idle with no start
        any = 1'b0;
        repeat (100) begin
            @(negedge clk);
            any |= busy | theta_valid_o | cos_neg_o | (|theta_o);
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
            any |= res_valid_o | res_cos_neg_o;
`endif
        end
        check("idle_quiet", 64'(any), 64'd0);

        // Quarter steps, cycle-exact
        clear_q();
        cap_en = 1'b1;
        pulse_start(32'h4000_0000, 32'h0, 16'd4);
        s0 = cyc;
        @(negedge clk);
        check("q_latency", 64'(theta_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("q_valid%0d", i), 64'(theta_valid_o), 64'd1);
            check($sformatf("q_theta%0d", i), 64'(theta_o), 64'(q2_theta[i]));
            check($sformatf("q_cos_neg%0d", i), 64'(cos_neg_o), 64'(q2_neg[i]));
        end
        repeat (DRAIN_EXTRA) @(negedge clk);
        check("q_busy_hold", 64'(busy), 64'd1);
        @(negedge clk);
        check("q_busy_drop", 64'(busy), 64'd0);
        check("q_valid_end", 64'(theta_valid_o), 64'd0);
`ifdef CORDIC_PHASE_FLAG_DELAY_EN
        check("res_count", 64'(r_neg.size()), 64'd4);
        if (r_cyc.size() == 4) begin
            check("res_align", 64'(r_cyc[0]), 64'(s0 + 2 + LAT));
            for (int i = 0; i < 4; i++)
                check($sformatf("res_cos_neg%0d", i), 64'(r_neg[i]), 64'(q2_neg[i]));
        end
        check("res_valid_end", 64'(res_valid_o), 64'd0);
`endif

        // Continuous wrap, stopped after 38 issues
        clear_q();
        pulse_start(32'hF000_0000, 32'h1000_0000, 16'd0);
        s0 = cyc;
        repeat (38) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        sedge = cyc;
        wait_idle("wrap_idle", 100 + LAT);
        check("wrap_count", 64'(q_theta.size()), 64'd38);
        for (int i = 0; i < q_theta.size(); i++)
            check($sformatf("wrap_s%0d", i), {31'd0, q_neg[i], q_theta[i]},
                  64'(model(32'h1000_0000 + 32'(i) * 32'hF000_0000)));
        if (q_cyc.size() > 0)
            check("wrap_last_valid", 64'(q_cyc[q_cyc.size()-1]), 64'(sedge));

        // Fold boundaries, single-sample bursts
        for (int k = 0; k < 4; k++) begin
            clear_q();
            pulse_start(32'h0, b_ofs[k], 16'd1);
            wait_idle($sformatf("bnd_idle%0d", k), 20 + LAT);
            check($sformatf("bnd_count%0d", k), 64'(q_theta.size()), 64'd1);
            if (q_theta.size() == 1) begin
                check($sformatf("bnd_theta%0d", k), 64'(q_theta[0]), 64'(b_theta[k]));
                check($sformatf("bnd_cos_neg%0d", k), 64'(q_neg[0]), 64'(b_neg[k]));
            end
        end

        // start and stop together in IDLE
        clear_q();
        @(negedge clk);
        ftw = 32'h1000_0000; phase_ofs = '0; burst_len = 16'd3;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("coll_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("coll_no_output", 64'(q_theta.size()), 64'd0);

        // start during RUN is ignored
        clear_q();
        pulse_start(32'h1000_0000, 32'h0, 16'd5);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("rerun_idle", 20 + LAT);
        check("rerun_count", 64'(q_theta.size()), 64'd5);

        // Reset mid-burst, then a fresh burst
        clear_q();
        pulse_start(32'h1000_0000, 32'h0, 16'd10);
        repeat (3) @(negedge clk);
        check("mid_valid", 64'(theta_valid_o), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(theta_valid_o), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_theta", 64'(theta_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        pulse_start(32'h4000_0000, 32'h0, 16'd2);
        wait_idle("fresh_idle", 20 + LAT);
        check("fresh_count", 64'(q_theta.size()), 64'd2);
        if (q_theta.size() == 2) begin
            check("fresh_theta0", 64'(q_theta[0]), 64'd0);
            check("fresh_theta1", 64'(q_theta[1]), 64'(H));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
